// File: rtl/viterbi_ber_sequencer.sv
// Frame-level controller for an encoder -> channel -> Viterbi decoder chain.
// Emits an LFSR payload followed by a zero tail, schedules a periodic burst
// error mask for the channel, and counts channel flips and decoded bit errors.
// rst is asynchronous and active low.
module viterbi_ber_sequencer #(
    parameter int          FRAME_LEN = 256,
    parameter int          TAIL_LEN  = 8,
    parameter int          DEC_LAT   = 24,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [5:0]  err_period_i,
    input  logic [5:0]  err_burst_i,
    input  logic [1:0]  err_mode_i,
    input  logic        decoder_i,
    output logic        enable_enc_o,
    output logic        encoder_d_o,
    output logic [1:0]  err_mask_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] dec_err_ct_o
);

    localparam int CNT_W = $clog2(FRAME_LEN + TAIL_LEN + DEC_LAT + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               accept;
    logic               last_drain;
    logic               enc_en;
    logic               enc_d;

    logic [15:0]        lfsr_reg;
    logic [5:0]         period_reg;
    logic [5:0]         burst_reg;
    logic [1:0]         mode_reg;
    logic [5:0]         phase_reg;
    logic               corrupt;
    logic [1:0]         mask_reg;
    logic               done_reg;
    logic [15:0]        bit_err_reg;
    logic [15:0]        dec_err_reg;

    // Compare line: each stage holds {payload_valid, bit}.
    logic [1:0]         line_reg  [DEC_LAT];
    logic [1:0]         line_next [DEC_LAT];

    logic [1:0]         mask_pop;
    logic [16:0]        bit_sum;
    logic [16:0]        dec_sum;
    logic               dec_hit;

    // State register and phase counter within the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and encoder drive.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        last_drain = 1'b0;
        enc_en     = 1'b0;
        enc_d      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                    cnt_next   = '0;
                end
            end
            S_RUN: begin
                enc_en = 1'b1;
                enc_d  = lfsr_reg[0];
                if (cnt_reg == CNT_W'(FRAME_LEN - 1)) begin
                    state_next = S_TAIL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_TAIL: begin
                enc_en = 1'b1;
                if (cnt_reg == CNT_W'(TAIL_LEN - 1)) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_reg == CNT_W'(DEC_LAT)) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    last_drain = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Latch the error configuration once per frame and step the payload LFSR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg   <= SEED;
            period_reg <= '0;
            burst_reg  <= '0;
            mode_reg   <= '0;
        end else if (accept) begin
            lfsr_reg   <= SEED;
            period_reg <= err_period_i;
            burst_reg  <= err_burst_i;
            mode_reg   <= err_mode_i;
        end else if (state_reg == S_RUN) begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                         lfsr_reg[15:1]};
        end
    end

    // The burst sits at the end of each period; a burst at least as long as
    // the period corrupts every symbol.
    always_comb begin
        corrupt = 1'b0;
        if (period_reg != 6'd0 && mode_reg != 2'd0) begin
            corrupt = (burst_reg >= period_reg) ||
                      (phase_reg >= (period_reg - burst_reg));
        end
    end

    // Symbol phase and registered channel mask; mode bit 0 targets sym[1].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg <= '0;
            mask_reg  <= '0;
        end else begin
            if (accept) begin
                phase_reg <= '0;
            end else if (enc_en) begin
                if (phase_reg == period_reg - 6'd1) begin
                    phase_reg <= '0;
                end else begin
                    phase_reg <= phase_reg + 6'd1;
                end
            end
            if (enc_en && corrupt) begin
                mask_reg <= {mode_reg[0], mode_reg[1]};
            end else begin
                mask_reg <= 2'b00;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEC_LAT; gi++) begin : g_line
            if (gi == 0) begin : g_head
                assign line_next[gi] = {state_reg == S_RUN, enc_d};
            end else begin : g_body
                assign line_next[gi] = line_reg[gi-1];
            end
        end
    endgenerate

    // Delay line that lines payload bits up with the decoder output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEC_LAT; i++) begin
                line_reg[i] <= 2'b00;
            end
        end else begin
            line_reg <= line_next;
        end
    end

    assign mask_pop = {1'b0, mask_reg[1]} + {1'b0, mask_reg[0]};
    assign bit_sum  = {1'b0, bit_err_reg} + 17'(mask_pop);
    assign dec_hit  = line_reg[DEC_LAT-1][1] && (line_reg[DEC_LAT-1][0] != decoder_i);
    assign dec_sum  = {1'b0, dec_err_reg} + 17'(dec_hit);

    // Saturating per-frame error counters, cleared on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_err_reg <= '0;
            dec_err_reg <= '0;
        end else if (accept) begin
            bit_err_reg <= '0;
            dec_err_reg <= '0;
        end else begin
            bit_err_reg <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
            dec_err_reg <= dec_sum[16] ? 16'hFFFF : dec_sum[15:0];
        end
    end

    // One-cycle completion pulse as the drain finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= last_drain;
        end
    end

    assign enable_enc_o = enc_en;
    assign encoder_d_o  = enc_d;
    assign err_mask_o   = mask_reg;
    assign busy_o       = (state_reg != S_IDLE);
    assign done_o       = done_reg;
    assign bit_err_ct_o = bit_err_reg;
    assign dec_err_ct_o = dec_err_reg;

endmodule
